// File: rtl/pipeline_if_stage.sv
// pipeline_if_stage
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS
// pipeline. The stage owns the fetch PC and runs the request/ready handshake
// with instruction memory. It presents the fetched word and its PC to ID.
// It follows ID's hold (shouldStall) and redirect (shouldJumpOrBranch)
// controls. A redirect takes priority over a hold.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   shouldStall         - ID requests IF/ID hold; fetched data is not consumed
//   shouldJumpOrBranch  - ID requests redirect to jumpTarget and a squash
//   jumpTarget[31:0]    - redirect target computed in ID
//   imem_req            - fetch request, held until imem_ready
//   imem_addr[31:0]     - fetch address (fetch PC), stable while imem_req=1
//   imem_rdata[31:0]    - instruction word, valid with imem_ready
//   imem_ready          - access completes this cycle
//   id_instruction/id_pc/id_valid - IF/ID register contents
//   if_state[1:0]       - FSM state (IDLE=0, WAIT=1, HOLD=2, KILL=3)
module pipeline_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic [1:0]  if_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } if_state_e;

  if_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] id_instruction_q, id_instruction_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic        imem_req_q, imem_req_d;

  // The FSM signals that a fresh word should enter IF/ID this edge.
  logic        load_s;
  logic [31:0] load_instr_s;
  logic [31:0] load_pc_s;

  // Next-state logic: fetch FSM, fetch PC, redirect PC and hold buffer
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    load_s        = 1'b0;
    load_instr_s  = BUBBLE;
    load_pc_s     = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (shouldJumpOrBranch && imem_ready) begin
          // The completing word belongs to the wrong path: discard it.
          fetch_pc_d = jumpTarget;
        end else if (shouldJumpOrBranch) begin
          // The access is in flight and cannot be cancelled. Park the target
          // until memory answers.
          redirect_pc_d = jumpTarget;
          state_d       = S_KILL;
        end else if (imem_ready && !shouldStall) begin
          load_s       = 1'b1;
          load_instr_s = imem_rdata;
          load_pc_s    = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + 32'd4;
        end else if (imem_ready) begin
          buf_instr_d = imem_rdata;
          buf_pc_d    = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + 32'd4;
          state_d     = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (shouldJumpOrBranch) begin
          buf_instr_d = BUBBLE;
          buf_pc_d    = RESET_PC;
          fetch_pc_d  = jumpTarget;
          state_d     = S_WAIT;
        end else if (!shouldStall) begin
          load_s       = 1'b1;
          load_instr_s = buf_instr_q;
          load_pc_s    = buf_pc_q;
          state_d      = S_WAIT;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_KILL: begin
        if (shouldJumpOrBranch) begin
          redirect_pc_d = jumpTarget;
        end else begin
          redirect_pc_d = redirect_pc_q;
        end
        if (imem_ready) begin
          // A redirect arriving on the completion cycle is newer than the
          // parked target.
          fetch_pc_d = shouldJumpOrBranch ? jumpTarget : redirect_pc_q;
          state_d    = S_WAIT;
        end else begin
          state_d = S_KILL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // IF/ID register next value: the redirect squashes, a stall holds, and an
  // idle edge injects a bubble so that ID never re-executes a word.
  always_comb begin
    id_instruction_d = id_instruction_q;
    id_pc_d          = id_pc_q;
    id_valid_d       = id_valid_q;
    if (shouldJumpOrBranch) begin
      id_instruction_d = BUBBLE;
      id_valid_d       = 1'b0;
    end else if (shouldStall) begin
      id_instruction_d = id_instruction_q;
    end else if (load_s) begin
      id_instruction_d = load_instr_s;
      id_pc_d          = load_pc_s;
      id_valid_d       = 1'b1;
    end else begin
      id_instruction_d = BUBBLE;
      id_valid_d       = 1'b0;
    end
  end

  // The request is registered from the next state. It is high while an
  // access is outstanding.
  always_comb begin
    if ((state_d == S_WAIT) || (state_d == S_KILL)) begin
      imem_req_d = 1'b1;
    end else begin
      imem_req_d = 1'b0;
    end
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      fetch_pc_q       <= RESET_PC;
      redirect_pc_q    <= RESET_PC;
      buf_instr_q      <= BUBBLE;
      buf_pc_q         <= RESET_PC;
      id_instruction_q <= BUBBLE;
      id_pc_q          <= RESET_PC;
      id_valid_q       <= 1'b0;
      imem_req_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      redirect_pc_q    <= redirect_pc_d;
      buf_instr_q      <= buf_instr_d;
      buf_pc_q         <= buf_pc_d;
      id_instruction_q <= id_instruction_d;
      id_pc_q          <= id_pc_d;
      id_valid_q       <= id_valid_d;
      imem_req_q       <= imem_req_d;
    end
  end

  assign imem_req       = imem_req_q;
  assign imem_addr      = fetch_pc_q;
  assign id_instruction = id_instruction_q;
  assign id_pc          = id_pc_q;
  assign id_valid       = id_valid_q;
  assign if_state       = state_q;

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Directed testbench for pipeline_if_stage. A small instruction memory
// returns addr|1 after a programmable latency. Expected values are computed
// by hand from the fetch/IF-ID rules.
module tb_pipeline_if_stage;

  logic        clk;
  logic        rst;
  logic        shouldStall;
  logic        shouldJumpOrBranch;
  logic [31:0] jumpTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [1:0]  if_state;

  int unsigned n_checks;
  int unsigned n_pass;

  // memory model state
  int          mem_lat;
  int          mem_cnt;
  logic        seen_200;

  pipeline_if_stage dut (
    .clk                (clk),
    .rst                (rst),
    .shouldStall        (shouldStall),
    .shouldJumpOrBranch (shouldJumpOrBranch),
    .jumpTarget         (jumpTarget),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .imem_ready         (imem_ready),
    .id_instruction     (id_instruction),
    .id_pc              (id_pc),
    .id_valid           (id_valid),
    .if_state           (if_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ready = imem_req && (mem_cnt == mem_lat - 1);
  assign imem_rdata = imem_addr | 32'h0000_0001;

  // Memory latency counter. It shares the reset with the design and
  // restarts after each completed access.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ready) begin
      mem_cnt <= 0;
    end else begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  // Record whether the abandoned target 0x200 was ever requested.
  always @(posedge clk) begin
    if (imem_req && (imem_addr == 32'h0000_0200)) begin
      seen_200 <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and then settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic v);
    check_eq({tag, ".instr"}, id_instruction, ins);
    check_eq({tag, ".pc"}, id_pc, pc);
    check_eq({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
  endtask

  task automatic check_fetch(input string tag, input logic [1:0] st, input logic req,
                             input logic [31:0] addr);
    check_eq({tag, ".state"}, {30'd0, if_state}, {30'd0, st});
    check_eq({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    check_eq({tag, ".addr"}, imem_addr, addr);
  endtask

  // Reset for two edges, release it, and take the IDLE->WAIT edge.
  task automatic do_reset();
    rst = 1'b1;
    shouldStall = 1'b0;
    shouldJumpOrBranch = 1'b0;
    jumpTarget = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    mem_lat = 1;
    mem_cnt = 0;
    seen_200 = 1'b0;
    rst = 1'b1;
    shouldStall = 1'b0;
    shouldJumpOrBranch = 1'b0;
    jumpTarget = 32'h0;

    // ---- reset state and sequential fetch, single-cycle memory ----
    tick();
    tick();
    check_fetch("rst", 2'd0, 1'b0, 32'h0);
    check_id("rst", 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    check_fetch("first_req", 2'd1, 1'b1, 32'h0);
    check_id("first_req", 32'h0, 32'h0, 1'b0);
    tick();
    check_id("seq0", 32'h1, 32'h0, 1'b1);
    check_eq("seq0.addr", imem_addr, 32'h4);
    tick();
    check_id("seq1", 32'h5, 32'h4, 1'b1);
    tick();
    check_id("seq2", 32'h9, 32'h8, 1'b1);
    check_eq("seq2.addr", imem_addr, 32'hC);

    // ---- 3-cycle memory: bubbles between fetches, stable request ----
    mem_lat = 3;
    do_reset();
    tick();
    check_fetch("lat3.c1", 2'd1, 1'b1, 32'h0);
    check_id("lat3.c1", 32'h0, 32'h0, 1'b0);
    tick();
    check_fetch("lat3.c2", 2'd1, 1'b1, 32'h0);
    tick();
    check_id("lat3.w0", 32'h1, 32'h0, 1'b1);
    check_eq("lat3.w0.addr", imem_addr, 32'h4);
    tick();
    check_id("lat3.gap", 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    check_id("lat3.w1", 32'h5, 32'h4, 1'b1);

    // ---- stall for 3 cycles while a fetch completes ----
    mem_lat = 1;
    do_reset();
    tick();
    check_id("stall.pre", 32'h1, 32'h0, 1'b1);
    shouldStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetch("stall.hold", 2'd2, 1'b0, 32'h8);
      check_id("stall.hold", 32'h1, 32'h0, 1'b1);
    end
    shouldStall = 1'b0;
    tick();
    check_id("stall.release", 32'h5, 32'h4, 1'b1);
    check_fetch("stall.release", 2'd1, 1'b1, 32'h8);
    tick();
    check_id("stall.next", 32'h9, 32'h8, 1'b1);

    // ---- redirect with single-cycle memory ----
    shouldJumpOrBranch = 1'b1;
    jumpTarget = 32'h0000_0100;
    tick();
    shouldJumpOrBranch = 1'b0;
    check_id("redir.squash", 32'h0, 32'h8, 1'b0);
    check_fetch("redir.addr", 2'd1, 1'b1, 32'h100);
    tick();
    check_id("redir.target", 32'h101, 32'h100, 1'b1);

    // ---- redirect during a 3-cycle access, then a re-redirect in KILL ----
    mem_lat = 3;
    do_reset();
    seen_200 = 1'b0;
    shouldJumpOrBranch = 1'b1;
    jumpTarget = 32'h0000_0200;
    tick();
    check_fetch("kill.enter", 2'd3, 1'b1, 32'h0);
    check_id("kill.enter", 32'h0, 32'h0, 1'b0);
    jumpTarget = 32'h0000_0300;
    tick();
    shouldJumpOrBranch = 1'b0;
    check_fetch("kill.stay", 2'd3, 1'b1, 32'h0);
    tick();
    check_fetch("kill.exit", 2'd1, 1'b1, 32'h300);
    check_id("kill.exit", 32'h0, 32'h0, 1'b0);
    tick();
    check_eq("kill.w1.valid", {31'd0, id_valid}, 32'd0);
    tick();
    check_eq("kill.w2.valid", {31'd0, id_valid}, 32'd0);
    tick();
    check_id("kill.target", 32'h301, 32'h300, 1'b1);
    check_eq("kill.no200", {31'd0, seen_200}, 32'd0);

    // ---- PC wrap at the top of the address space ----
    mem_lat = 1;
    do_reset();
    shouldJumpOrBranch = 1'b1;
    jumpTarget = 32'hFFFF_FFFC;
    tick();
    shouldJumpOrBranch = 1'b0;
    check_eq("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_id("wrap.word", 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b1);
    check_eq("wrap.addr1", imem_addr, 32'h0);

    // ---- reset asserted while in KILL ----
    mem_lat = 3;
    do_reset();
    shouldJumpOrBranch = 1'b1;
    jumpTarget = 32'h0000_0040;
    tick();
    shouldJumpOrBranch = 1'b0;
    check_eq("rstkill.state", {30'd0, if_state}, 32'd3);
    rst = 1'b1;
    tick();
    check_fetch("rstkill.rst", 2'd0, 1'b0, 32'h0);
    check_eq("rstkill.valid", {31'd0, id_valid}, 32'd0);
    rst = 1'b0;
    tick();
    check_fetch("rstkill.restart", 2'd1, 1'b1, 32'h0);
    tick();
    tick();
    tick();
    check_id("rstkill.word", 32'h1, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_if_stage.md
Name: pipeline_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; directly upstream of the ID-stage control decoder.
- Owns the fetch PC and the handshake with instruction memory.
- Presents `id_instruction` and `id_pc` to ID.
- Obeys ID's `shouldStall` (hold) and `shouldJumpOrBranch` (redirect to the ID-computed target and squash to bubble 32'h0, which ID treats as a NOP).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUBBLE, 32'h0000_0000, instruction word injected into IF/ID on squash or when no fetch is available.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- shouldStall  input  1  from ID control; hold IF/ID and do not consume fetched data.
- shouldJumpOrBranch  input  1  from ID control; redirect; priority over shouldStall.
- jumpTarget  input  32  target PC for the redirect (j/jal/jr/taken branch), computed in ID.
- imem_req  output  1  fetch request, held until imem_ready.
- imem_addr  output  32  fetch address (= fetch_pc); stable while imem_req=1.
- imem_rdata  input  32  instruction word, valid when imem_ready=1.
- imem_ready  input  1  access complete this cycle; ignored when imem_req=0.
- id_instruction  output  32  IF/ID instruction register.
- id_pc  output  32  PC of id_instruction.
- id_valid  output  1  1 = real instruction, 0 = bubble.
- if_state  output  2  FSM state, for debug.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, fetch_pc=RESET_PC, redirect_pc=RESET_PC.
  - id_instruction=BUBBLE, id_pc=RESET_PC, id_valid=0, hold buffer cleared.
  - imem_req=0.
  - Reset mid-access abandons the access; memory shares rst.
- States: IDLE=0, WAIT=1, HOLD=2, KILL=3.
- imem_req=1 in WAIT and KILL, 0 otherwise. imem_addr=fetch_pc always.
- IDLE: go to WAIT next cycle (first request one cycle after reset release).
- WAIT transitions, first match wins:
  - Redirect with imem_ready=1: discard data; fetch_pc<=jumpTarget; stay WAIT.
  - Redirect with imem_ready=0: redirect_pc<=jumpTarget; go to KILL.
  - imem_ready=1 and !shouldStall: load IF/ID {imem_rdata, fetch_pc, valid=1}; fetch_pc<=fetch_pc+4; stay WAIT.
  - imem_ready=1 and shouldStall: buffer<={imem_rdata, fetch_pc}; fetch_pc<=fetch_pc+4; go to HOLD.
  - imem_ready=0: stay WAIT.
- HOLD (no request outstanding):
  - Redirect: drop buffer; fetch_pc<=jumpTarget; go to WAIT.
  - !shouldStall: load IF/ID from buffer with valid=1; go to WAIT.
  - Otherwise stay HOLD.
- KILL (abandoned access still in flight; imem_addr keeps the old fetch_pc):
  - A further redirect overwrites redirect_pc (latest wins).
  - imem_ready=1: discard data; fetch_pc<=redirect_pc, or jumpTarget if a redirect arrives that same cycle; go to WAIT.
- IF/ID register, per edge, first match wins:
  - rst: reset values.
  - shouldJumpOrBranch: {BUBBLE, id_pc unchanged, 0}.
  - shouldStall: hold.
  - Load per FSM above.
  - Otherwise: {BUBBLE, id_pc unchanged, 0}, so ID never re-executes an instruction.
- Redirect latency: first instruction at the target appears in IF/ID no earlier than 2 cycles after the redirect edge with single-cycle memory.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0). No alignment checking; low 2 bits of jumpTarget pass through.
- Simultaneous shouldStall and shouldJumpOrBranch (normal for jumps): treat as redirect.

Test Plan:
- Reset, imem_ready tied 1, rdata = addr|32'h1 → imem_addr 0,4,8…; id_instruction 32'h1,32'h5,32'h9 on consecutive cycles, first valid 2 cycles after rst release; id_pc tracks.
- Memory latency 3 cycles, no stall → imem_req held with stable addr; id_valid=0 / BUBBLE between fetches; each word delivered exactly once.
- shouldStall held for 3 cycles while a fetch completes → state HOLD, imem_req=0, IF/ID unchanged; after release the buffered word with correct id_pc is loaded; no fetch skipped or duplicated.
- shouldJumpOrBranch=1 with jumpTarget=32'h100, single-cycle memory → IF/ID=BUBBLE next edge; imem_addr=32'h100 next cycle; id_pc=32'h100 valid 2 cycles after redirect.
- Redirect during a 3-cycle access (target 32'h200), then a second redirect to 32'h300 while in KILL → old data discarded, no valid output until the word from 32'h300; 32'h200 never fetched.
- fetch_pc=32'hFFFF_FFFC → next imem_addr=32'h0. Assert rst during KILL → IDLE, id_valid=0, next fetch at RESET_PC.
